siphash_msg_ctrl: RTL and testbench



---
 rtl/siphash_pkg.sv | 24 ++
 rtl/siphash_msg_ctrl_if.sv | 12 +
 rtl/siphash_last_block.sv | 20 ++
 rtl/siphash_msg_ctrl.sv | 147 ++++++++++++++
 tb/tb_siphash_msg_ctrl.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/siphash_pkg.sv
// Shared types and constants for the SipHash message front end.
// Covers the sequencer state encoding, default round counts and the padding position.
package siphash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_ACCEPT,
    ST_COMP,
    ST_WAIT_C,
    ST_FIN,
    ST_WAIT_F
  } state_t;

  localparam int C_ROUNDS_DEF = 2;
  localparam int D_ROUNDS_DEF = 4;
  localparam int PAD_POS      = 56;

  // Byte counts above a full word are treated as a full word.
  function automatic logic [3:0] clamp_bytes(input logic [3:0] n);
    return (n > 4'd8) ? 4'd8 : n;
  endfunction

endpackage

// File: rtl/siphash_msg_ctrl_if.sv
// Message word stream into the SipHash front end.
// Uses a valid/ready handshake; bytes is meaningful only on the last word.
interface siphash_msg_ctrl_if;
  logic        valid;
  logic        ready;
  logic [63:0] word;
  logic        last;
  logic [3:0]  bytes;

  modport master (output valid, word, last, bytes, input ready);
  modport slave  (input valid, word, last, bytes, output ready);
endinterface

// File: rtl/siphash_last_block.sv
// Builds the final SipHash block from a partial word.
// Bytes at or above nbytes are zeroed, and the top byte carries the message length mod 256.
module siphash_last_block
  import siphash_pkg::*;
(
  input  logic [63:0] word,
  input  logic [3:0]  nbytes,
  input  logic [7:0]  len,
  output logic [63:0] mi
);

  always_comb begin
    mi = '0;
    for (int i = 0; i < 7; i++) begin
      if (4'(i) < nbytes) mi[8*i +: 8] = word[8*i +: 8];
    end
    mi[63:PAD_POS] = len + {4'd0, nbytes};
  end

endmodule

// File: rtl/siphash_msg_ctrl.sv
// Message front end and command sequencer for siphash_core.
// Pads the message stream and hides the core's init/compress/finalise protocol.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for start while the core is ready
// ST_INIT   | core_initalize pulse
// ST_ACCEPT | in_ready follows core_ready, capture the next word
// ST_COMP   | core_compress pulse with mi_reg on core_mi
// ST_WAIT_C | wait for the core, then pad, finalise or accept more
// ST_FIN    | core_finalize pulse
// ST_WAIT_F | wait for the core result and fold it into the tag
module siphash_msg_ctrl
  import siphash_pkg::*;
#(
  parameter int C_ROUNDS = C_ROUNDS_DEF,
  parameter int D_ROUNDS = D_ROUNDS_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [127:0]        key,
  siphash_msg_ctrl_if.slave   msg,
  output logic                busy,
  output logic                tag_valid,
  output logic [63:0]         tag,
  output logic                core_initalize,
  output logic                core_compress,
  output logic                core_finalize,
  output logic                core_long,
  output logic [127:0]        core_key,
  output logic [63:0]         core_mi,
  output logic [3:0]          core_compression_rounds,
  output logic [3:0]          core_final_rounds,
  input  logic                core_ready,
  input  logic                core_word_valid,
  input  logic [127:0]        core_word
);

  state_t       state;
  logic [127:0] key_reg;
  logic [63:0]  mi_reg;
  logic [63:0]  tag_reg;
  logic [63:0]  last_mi;
  logic [7:0]   len_reg;
  logic         pad_pending;
  logic         final_pending;
  logic [3:0]   nbytes;
  logic         hs;

  assign nbytes    = clamp_bytes(msg.bytes);
  assign msg.ready = (state == ST_ACCEPT) && core_ready;
  assign hs        = msg.valid && msg.ready;

  assign core_long               = 1'b0;
  assign core_key                = key_reg;
  assign core_mi                 = mi_reg;
  assign tag                     = tag_reg;
  assign core_compression_rounds = 4'(C_ROUNDS);
  assign core_final_rounds       = 4'(D_ROUNDS);

  siphash_last_block u_last_block (
    .word   (msg.word),
    .nbytes (nbytes),
    .len    (len_reg),
    .mi     (last_mi)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      key_reg        <= '0;
      mi_reg         <= '0;
      tag_reg        <= '0;
      len_reg        <= '0;
      pad_pending    <= 1'b0;
      final_pending  <= 1'b0;
      busy           <= 1'b0;
      tag_valid      <= 1'b0;
      core_initalize <= 1'b0;
      core_compress  <= 1'b0;
      core_finalize  <= 1'b0;
    end else begin
      core_initalize <= 1'b0;
      core_compress  <= 1'b0;
      core_finalize  <= 1'b0;
      tag_valid      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && core_ready) begin
            key_reg        <= key;
            len_reg        <= '0;
            pad_pending    <= 1'b0;
            final_pending  <= 1'b0;
            busy           <= 1'b1;
            core_initalize <= 1'b1;
            state          <= ST_INIT;
          end
        end
        ST_INIT: state <= ST_ACCEPT;
        ST_ACCEPT: begin
          if (hs) begin
            // A full last word still needs a separate length-only block.
            if (msg.last && (nbytes != 4'd8)) begin
              mi_reg        <= last_mi;
              final_pending <= 1'b1;
            end else begin
              mi_reg      <= msg.word;
              len_reg     <= len_reg + 8'd8;
              pad_pending <= msg.last;
            end
            core_compress <= 1'b1;
            state         <= ST_COMP;
          end
        end
        ST_COMP: state <= ST_WAIT_C;
        ST_WAIT_C: begin
          if (core_ready) begin
            if (pad_pending) begin
              mi_reg        <= {len_reg, 56'h0};
              pad_pending   <= 1'b0;
              final_pending <= 1'b1;
              core_compress <= 1'b1;
              state         <= ST_COMP;
            end else if (final_pending) begin
              core_finalize <= 1'b1;
              state         <= ST_FIN;
            end else begin
              state <= ST_ACCEPT;
            end
          end
        end
        ST_FIN: state <= ST_WAIT_F;
        ST_WAIT_F: begin
          if (core_word_valid && core_ready) begin
            tag_reg   <= core_word[127:64] ^ core_word[63:0];
            tag_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_siphash_msg_ctrl.sv
// Bench for siphash_msg_ctrl: a behavioural SipHash core answers the command pulses
// with random latency, and tags are compared against a byte-level SipHash-2-4 reference.
module tb_siphash_msg_ctrl;
  import siphash_pkg::*;

  typedef logic [7:0]  bq_t[$];
  typedef logic [63:0] wq_t[$];

  localparam logic [127:0] TKEY = {64'h0f0e0d0c0b0a0908, 64'h0706050403020100};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic         busy, tag_valid;
  logic [63:0]  tag;
  logic         core_initalize, core_compress, core_finalize, core_long;
  logic [127:0] core_key;
  logic [63:0]  core_mi;
  logic [3:0]   core_compression_rounds, core_final_rounds;
  logic         core_ready = 1'b1;
  logic         core_word_valid = 1'b0;
  logic [127:0] core_word = '0;

  siphash_msg_ctrl_if msg ();

  siphash_msg_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .key(key), .msg(msg),
    .busy(busy), .tag_valid(tag_valid), .tag(tag),
    .core_initalize(core_initalize), .core_compress(core_compress),
    .core_finalize(core_finalize), .core_long(core_long),
    .core_key(core_key), .core_mi(core_mi),
    .core_compression_rounds(core_compression_rounds),
    .core_final_rounds(core_final_rounds),
    .core_ready(core_ready), .core_word_valid(core_word_valid), .core_word(core_word)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- SipHash arithmetic ----------------
  function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
    return (x << n) | (x >> (64 - n));
  endfunction

  function automatic logic [255:0] sip_round(input logic [255:0] v);
    logic [63:0] a, b, c, d;
    {d, c, b, a} = v;
    a = a + b; b = rotl(b, 13); b = b ^ a; a = rotl(a, 32);
    c = c + d; d = rotl(d, 16); d = d ^ c;
    a = a + d; d = rotl(d, 21); d = d ^ a;
    c = c + b; b = rotl(b, 17); b = b ^ c; c = rotl(c, 32);
    return {d, c, b, a};
  endfunction

  function automatic logic [255:0] sip_init(input logic [127:0] k);
    return {k[127:64] ^ 64'h7465646279746573, k[63:0] ^ 64'h6c7967656e657261,
            k[127:64] ^ 64'h646f72616e646f6d, k[63:0] ^ 64'h736f6d6570736575};
  endfunction

  function automatic logic [255:0] sip_comp(input logic [255:0] v, input logic [63:0] m, input int n);
    v[255:192] = v[255:192] ^ m;
    for (int i = 0; i < n; i++) v = sip_round(v);
    v[63:0] = v[63:0] ^ m;
    return v;
  endfunction

  function automatic logic [255:0] sip_fin(input logic [255:0] v, input int n);
    v[191:128] = v[191:128] ^ 64'hff;
    for (int i = 0; i < n; i++) v = sip_round(v);
    return v;
  endfunction

  // Blocks of a byte message as SipHash defines them, length byte in the last block.
  function automatic wq_t ref_blocks(input bq_t m);
    wq_t q;
    int n, full;
    logic [63:0] b;
    n = m.size();
    full = n / 8;
    for (int i = 0; i < full; i++) begin
      b = '0;
      for (int j = 0; j < 8; j++) b[8*j +: 8] = m[8*i + j];
      q.push_back(b);
    end
    b = '0;
    b[63:56] = n[7:0];
    for (int j = 0; j < n % 8; j++) b[8*j +: 8] = m[8*full + j];
    q.push_back(b);
    return q;
  endfunction

  function automatic logic [63:0] ref_hash(input logic [127:0] k, input bq_t m);
    wq_t q;
    logic [255:0] v;
    q = ref_blocks(m);
    v = sip_init(k);
    foreach (q[i]) v = sip_comp(v, q[i], 2);
    v = sip_fin(v, 4);
    return v[63:0] ^ v[127:64] ^ v[191:128] ^ v[255:192];
  endfunction

  // ---------------- behavioural core ----------------
  logic [255:0] cv = '0;
  int           ccnt = 0;
  logic         cfin = 1'b0;

  always @(posedge clk) begin
    core_word_valid <= 1'b0;
    if (!reset_n) begin
      core_ready <= 1'b1;
      ccnt       <= 0;
      cfin       <= 1'b0;
    end else if (core_initalize) begin
      cv <= sip_init(core_key);
      core_ready <= 1'b0; ccnt <= int'($urandom_range(1, 4)); cfin <= 1'b0;
    end else if (core_compress) begin
      cv <= sip_comp(cv, core_mi, int'(core_compression_rounds));
      core_ready <= 1'b0; ccnt <= int'($urandom_range(1, 4));
    end else if (core_finalize) begin
      cv <= sip_fin(cv, int'(core_final_rounds));
      core_ready <= 1'b0; ccnt <= int'($urandom_range(1, 4)); cfin <= 1'b1;
    end else if (ccnt > 0) begin
      ccnt <= ccnt - 1;
      if (ccnt == 1) begin
        core_ready <= 1'b1;
        if (cfin) begin
          core_word_valid <= 1'b1;
          core_word <= {cv[63:0] ^ cv[127:64], cv[191:128] ^ cv[255:192]};
          cfin <= 1'b0;
        end
      end
    end
  end

  // ---------------- command monitor ----------------
  wq_t mi_seen;
  int  n_init = 0, n_comp = 0, n_fin = 0;

  always @(negedge clk) begin
    if (core_initalize) n_init++;
    if (core_compress) begin n_comp++; mi_seen.push_back(core_mi); end
    if (core_finalize) n_fin++;
    if (core_initalize || core_compress || core_finalize) begin
      checks++;
      if ((int'(core_initalize) + int'(core_compress) + int'(core_finalize)) != 1) begin
        failures++;
        $display("FAIL cmd_onehot init=%0b comp=%0b fin=%0b required one pulse",
                 core_initalize, core_compress, core_finalize);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [63:0] obs_tag = '0;
  logic        busy_at_tag = 1'b0;
  logic        tv_after = 1'b0;

  task automatic clear_mon();
    mi_seen.delete();
    n_init = 0; n_comp = 0; n_fin = 0;
  endtask

  task automatic do_start(input logic [127:0] k);
    int g;
    g = 0;
    @(negedge clk);
    start = 1'b1; key = k;
    while (!busy && g < 100) begin @(negedge clk); g++; end
    start = 1'b0; key = '0;
    checks++;
    if (!busy) begin
      failures++;
      $display("FAIL start_accept busy=%0b required=1", busy);
    end else begin
      checks++;
      if (core_initalize !== 1'b1 || core_key !== k) begin
        failures++;
        $display("FAIL start_init init=%0b key=%h required init=1 key=%h", core_initalize, core_key, k);
      end
    end
  endtask

  task automatic send_words(input bq_t m, input int pct, input int upto, input bit noisy);
    int n, nw, base, cnt, g;
    bit hs;
    logic [63:0] d;
    n = m.size();
    nw = (n == 0) ? 1 : (n + 7) / 8;
    for (int w = 0; w < nw && w < upto; w++) begin
      base = 8 * w;
      cnt = n - base;
      if (cnt > 8) cnt = 8;
      for (int j = 0; j < 8; j++) begin
        if (j < cnt) d[8*j +: 8] = m[base + j];
        else d[8*j +: 8] = 8'($urandom);
      end
      msg.word = d;
      msg.last = (w == nw - 1);
      if (w == nw - 1) msg.bytes = (cnt == 8) ? 4'($urandom_range(8, 15)) : 4'(cnt);
      else msg.bytes = 4'($urandom_range(0, 15));
      hs = 1'b0; g = 0;
      while (!hs && g < 500) begin
        msg.valid = ($urandom_range(0, 99) < pct);
        if (noisy) start = 1'($urandom_range(0, 1));
        #1;
        hs = msg.valid && msg.ready;
        @(negedge clk);
        g++;
      end
      msg.valid = 1'b0;
      start = 1'b0;
      if (!hs) begin
        checks++; failures++;
        $display("FAIL word_handshake word=%0d accepted=0 required=1", w);
        return;
      end
    end
  endtask

  task automatic wait_tag();
    int g;
    g = 0;
    while (!tag_valid && g < 3000) begin @(negedge clk); g++; end
    checks++;
    if (!tag_valid) begin
      failures++;
      $display("FAIL tag_timeout tag_valid=0 required=1");
    end
    obs_tag = tag;
    busy_at_tag = busy;
    @(negedge clk);
    tv_after = tag_valid;
  endtask

  task automatic run_msg(input bq_t m, input int pct, input bit noisy);
    clear_mon();
    do_start(TKEY);
    send_words(m, pct, 1 << 20, noisy);
    wait_tag();
  endtask

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if ({busy, tag_valid, core_initalize, core_compress, core_finalize, msg.ready, core_long} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b required=0000000",
               {busy, tag_valid, core_initalize, core_compress, core_finalize, msg.ready, core_long});
    end
    checks++;
    if (tag !== 64'h0) begin failures++; $display("FAIL reset_tag got=%h required=0", tag); end
    checks++;
    if (core_mi !== 64'h0) begin failures++; $display("FAIL reset_mi got=%h required=0", core_mi); end
    checks++;
    if (core_key !== 128'h0) begin failures++; $display("FAIL reset_key got=%h required=0", core_key); end
    checks++;
    if (core_compression_rounds !== 4'd2 || core_final_rounds !== 4'd4) begin
      failures++;
      $display("FAIL rounds got=%0d/%0d required=2/4", core_compression_rounds, core_final_rounds);
    end
  endtask

  task automatic test_empty();
    bq_t m;
    m.delete();
    run_msg(m, 100, 1'b0);
    checks++;
    if (obs_tag !== 64'h726fdb47dd0e0e31) begin
      failures++; $display("FAIL empty_tag got=%h required=726fdb47dd0e0e31", obs_tag);
    end
    checks++;
    if (n_comp !== 1 || n_fin !== 1) begin
      failures++; $display("FAIL empty_cmds comp=%0d fin=%0d required=1/1", n_comp, n_fin);
    end
    checks++;
    if (mi_seen.size() < 1 || mi_seen[0] !== 64'h0) begin
      failures++; $display("FAIL empty_mi got=%h required=0", (mi_seen.size() > 0) ? mi_seen[0] : 64'hx);
    end
  endtask

  task automatic test_fifteen();
    bq_t m;
    m.delete();
    for (int i = 0; i < 15; i++) m.push_back(8'(i));
    run_msg(m, 100, 1'b0);
    checks++;
    if (obs_tag !== 64'ha129ca6149be45e5) begin
      failures++; $display("FAIL fifteen_tag got=%h required=a129ca6149be45e5", obs_tag);
    end
    checks++;
    if (mi_seen.size() != 2 || mi_seen[1] !== 64'h0f0e0d0c0b0a0908) begin
      failures++; $display("FAIL fifteen_mi count=%0d last=%h required=2 0f0e0d0c0b0a0908",
                           mi_seen.size(), (mi_seen.size() > 1) ? mi_seen[1] : 64'hx);
    end
  endtask

  task automatic test_eight();
    bq_t m;
    m.delete();
    for (int i = 0; i < 8; i++) m.push_back(8'(i));
    run_msg(m, 100, 1'b0);
    checks++;
    if (n_comp !== 2 || mi_seen.size() != 2 || mi_seen[1] !== 64'h0800000000000000) begin
      failures++; $display("FAIL eight_pad comp=%0d last=%h required=2 0800000000000000",
                           n_comp, (mi_seen.size() > 1) ? mi_seen[1] : 64'hx);
    end
    checks++;
    if (obs_tag !== ref_hash(TKEY, m)) begin
      failures++; $display("FAIL eight_tag got=%h required=%h", obs_tag, ref_hash(TKEY, m));
    end
  endtask

  task automatic test_long_toggle();
    bq_t m;
    wq_t eb;
    int bad;
    m = rand_bytes(264);
    eb = ref_blocks(m);
    run_msg(m, 45, 1'b0);
    checks++;
    if (obs_tag !== ref_hash(TKEY, m)) begin
      failures++; $display("FAIL long_tag got=%h required=%h", obs_tag, ref_hash(TKEY, m));
    end
    checks++;
    bad = (mi_seen.size() != eb.size()) ? 1 : 0;
    for (int i = 0; i < eb.size() && i < mi_seen.size(); i++) if (mi_seen[i] !== eb[i]) bad++;
    if (bad != 0) begin
      failures++; $display("FAIL long_blocks count=%0d required=%0d bad=%0d", mi_seen.size(), eb.size(), bad);
    end
    checks++;
    if (mi_seen.size() != 34 || mi_seen[33] !== 64'h0800000000000000) begin
      failures++; $display("FAIL long_lenbyte last=%h required=0800000000000000",
                           (mi_seen.size() > 33) ? mi_seen[33] : 64'hx);
    end
  endtask

  task automatic test_random_lengths();
    bq_t m;
    wq_t eb;
    for (int it = 0; it < 6; it++) begin
      m = rand_bytes(int'($urandom_range(0, 40)));
      eb = ref_blocks(m);
      run_msg(m, 70, 1'b0);
      checks++;
      if (obs_tag !== ref_hash(TKEY, m) || n_comp != eb.size()) begin
        failures++; $display("FAIL rand_len%0d tag=%h comp=%0d required=%h %0d",
                             m.size(), obs_tag, n_comp, ref_hash(TKEY, m), eb.size());
      end
      checks++;
      if (busy_at_tag !== 1'b0 || tv_after !== 1'b0) begin
        failures++; $display("FAIL rand_pulse busy=%0b tv_next=%0b required=0 0", busy_at_tag, tv_after);
      end
    end
  endtask

  task automatic test_reset_mid();
    bq_t m;
    int g;
    m = rand_bytes(20);
    clear_mon();
    do_start(TKEY);
    send_words(m, 100, 1, 1'b0);
    g = 0;
    while (!(n_comp >= 1 && !core_compress && !core_ready) && g < 200) begin @(negedge clk); g++; end
    checks++;
    if (g >= 200) begin failures++; $display("FAIL reach_wait_c reached=0 required=1"); end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, tag_valid, core_initalize, core_compress, core_finalize, msg.ready} !== 6'b0) begin
      failures++; $display("FAIL midreset_ctrl got=%b required=000000",
                           {busy, tag_valid, core_initalize, core_compress, core_finalize, msg.ready});
    end
    checks++;
    if (tag !== 64'h0 || core_mi !== 64'h0 || core_key !== 128'h0) begin
      failures++; $display("FAIL midreset_data tag=%h mi=%h key=%h required=0", tag, core_mi, core_key);
    end
    reset_n = 1'b1;
    m = rand_bytes(13);
    run_msg(m, 100, 1'b0);
    checks++;
    if (obs_tag !== ref_hash(TKEY, m)) begin
      failures++; $display("FAIL after_reset_tag got=%h required=%h", obs_tag, ref_hash(TKEY, m));
    end
  endtask

  task automatic test_ignore();
    bq_t m;
    int bad;
    clear_mon();
    @(negedge clk);
    msg.valid = 1'b1; msg.last = 1'b1; msg.bytes = 4'd0; msg.word = {$urandom, $urandom};
    bad = 0;
    repeat (8) begin
      #1;
      if (msg.ready !== 1'b0) bad++;
      @(negedge clk);
    end
    msg.valid = 1'b0;
    checks++;
    if (bad != 0 || n_comp != 0 || busy !== 1'b0) begin
      failures++; $display("FAIL idle_valid ready_hits=%0d comp=%0d busy=%0b required=0 0 0", bad, n_comp, busy);
    end
    m = rand_bytes(30);
    run_msg(m, 60, 1'b1);
    checks++;
    if (n_init != 1) begin failures++; $display("FAIL start_busy inits=%0d required=1", n_init); end
    checks++;
    if (obs_tag !== ref_hash(TKEY, m)) begin
      failures++; $display("FAIL noisy_tag got=%h required=%h", obs_tag, ref_hash(TKEY, m));
    end
  endtask

  initial begin
    msg.valid = 1'b0; msg.word = '0; msg.last = 1'b0; msg.bytes = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    test_empty();
    test_fifteen();
    test_eight();
    test_long_toggle();
    test_random_lengths();
    test_reset_mid();
    test_ignore();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
